// File: rtl/mod_pkg.sv
// Shared widths and FSM state for the lazy-accumulate / reduce datapath.
// Used by the accumulator, its output slot and the reducer.
package mod_pkg;

  localparam int DIN_W     = 256;
  localparam int DOUT_W    = 300;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

endpackage

// File: rtl/mod_lazy_accum_if.sv
// Residue stream in / group sum out handshake bundle.
// Ports: in_valid/in_ready/din/in_last, out_valid/out_ready/x/out_cnt/out_trunc.
interface mod_lazy_accum_if;
  import mod_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  din;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] x;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_trunc;

  modport master (
    output in_valid, din, in_last, out_ready,
    input  in_ready, out_valid, x, out_cnt, out_trunc
  );

  modport slave (
    input  in_valid, din, in_last, out_ready,
    output in_ready, out_valid, x, out_cnt, out_trunc
  );

endinterface

// File: rtl/mod_out_slot.sv
// One-entry valid/ready register holding x/cnt/trunc of a finished group.
// Ports: clk, reset, load + ld_* data in, ready in, valid/x/cnt/trunc/free out.
module mod_out_slot
  import mod_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DOUT_W-1:0] ld_x,
  input  logic [CNT_W-1:0]  ld_cnt,
  input  logic              ld_trunc,
  input  logic              ready,
  output logic              valid,
  output logic [DOUT_W-1:0] x,
  output logic [CNT_W-1:0]  cnt,
  output logic              trunc,
  output logic              free
);

  // Slot is free when empty or draining this cycle.
  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      x     <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      x     <= ld_x;
      cnt   <= ld_cnt;
      trunc <= ld_trunc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_lazy_accum.sv
// Sums groups of residues unreduced into a wide word for the reducer.
// Ports: clk, reset (sync, active-high), bus (slave side of the stream).
module mod_lazy_accum
  import mod_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mod_lazy_accum_if.slave bus
);

  if (DOUT_W - DIN_W < $clog2(MAX_TERMS)) begin : g_width_chk
    $error("DOUT_W too narrow for MAX_TERMS");
  end

  state_t            state;
  logic [DOUT_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [DOUT_W-1:0] sum;
  logic [CNT_W-1:0]  cnt_nx;
  logic              free;
  logic              take;
  logic              flush;

  assign bus.in_ready = !reset && free;
  assign take = bus.in_valid && bus.in_ready;

  // A group's first beat starts from zero regardless of stale acc.
  assign sum = (state == IDLE ? '0 : acc)
             + DOUT_W'(bus.din);
  assign cnt_nx = (state == IDLE) ? CNT_W'(1)
                                  : cnt + 1'b1;
  assign flush = take && (bus.in_last ||
                 cnt_nx == CNT_W'(MAX_TERMS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (take) begin
      state <= ACC;
      acc   <= sum;
      cnt   <= cnt_nx;
    end
  end

  mod_out_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .load     (flush),
    .ld_x     (sum),
    .ld_cnt   (cnt_nx),
    .ld_trunc (!bus.in_last),
    .ready    (bus.out_ready),
    .valid    (bus.out_valid),
    .x        (bus.x),
    .cnt      (bus.out_cnt),
    .trunc    (bus.out_trunc),
    .free     (free)
  );

endmodule

// File: tb/tb_mod_lazy_accum.sv
// Self-checking bench for mod_lazy_accum: directed table plus random stream.
// Drives the master side of the interface; compares against a group model.
module tb_mod_lazy_accum;
  import mod_pkg::*;

  logic clk;
  logic reset;

  mod_lazy_accum_if bus ();

  mod_lazy_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    int               n;
    logic [DIN_W-1:0] base;
    logic [DIN_W-1:0] step;
    bit               last;
    logic [DOUT_W-1:0] ex;
    int               ecnt;
    bit               etr;
  } vec_t;

  typedef struct {
    logic [DOUT_W-1:0] x;
    int                cnt;
    bit                tr;
  } exp_t;

  vec_t             tv[6];
  exp_t             exp_q[$];
  logic [DIN_W-1:0] grp[$];

  task automatic chk(input string nm,
                     input logic [DOUT_W-1:0] got,
                     input logic [DOUT_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: collect beats of a group, sum them when it closes.
  task automatic model_beat(input logic [DIN_W-1:0] d,
                            input bit last);
    logic [DOUT_W-1:0] s;
    exp_t e;
    grp.push_back(d);
    if (last || grp.size() == MAX_TERMS) begin
      s = '0;
      foreach (grp[j]) s = s + DOUT_W'(grp[j]);
      e.x   = s;
      e.cnt = grp.size();
      e.tr  = !last;
      exp_q.push_back(e);
      grp.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("rand_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rand_x", bus.x, e.x);
        chk("rand_cnt", DOUT_W'(bus.out_cnt),
            DOUT_W'(e.cnt));
        chk("rand_trunc", DOUT_W'(bus.out_trunc),
            DOUT_W'(e.tr));
      end
    end
  end

  // Enter and leave at posedge+1.
  task automatic beat(input logic [DIN_W-1:0] d,
                      input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("beat_timeout", 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic step(input bit v,
                      input logic [DIN_W-1:0] d,
                      input bit last,
                      input bit ordy);
    bus.in_valid  = v;
    bus.din       = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("ready_rule", DOUT_W'(bus.in_ready),
        DOUT_W'(!bus.out_valid || bus.out_ready));
    if (v && bus.in_ready) model_beat(d, last);
    @(posedge clk); #1;
  endtask

  function automatic logic [DIN_W-1:0] rnd_din();
    logic [DIN_W-1:0] d;
    for (int i = 0; i < 8; i++)
      d[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) d = '1;
    return d;
  endfunction

  initial begin
    logic [DIN_W-1:0]  ones;
    logic [DOUT_W-1:0] ones_w;
    logic [DIN_W-1:0]  d;
    ones   = '1;
    ones_w = DOUT_W'(ones);

    tv[0] = '{3, 5, 2, 1, 21, 3, 0};
    tv[1] = '{16, ones, 0, 0, ones_w << 4, 16, 1};
    tv[2] = '{1, 42, 0, 1, 42, 1, 0};
    tv[3] = '{4, 100, 1, 1, 406, 4, 0};
    tv[4] = '{16, 1, 1, 1, 136, 16, 0};
    tv[5] = '{2, ones, 0, 1, ones_w << 1, 2, 0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset and idle.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", DOUT_W'(bus.in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_out_valid", DOUT_W'(bus.out_valid), 0);
    chk("idle_x", bus.x, 0);
    chk("idle_cnt", DOUT_W'(bus.out_cnt), 0);
    chk("idle_trunc", DOUT_W'(bus.out_trunc), 0);
    chk("idle_in_ready", DOUT_W'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Directed table.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < tv[k].n; i++) begin
        d = tv[k].base + tv[k].step * DIN_W'(i);
        beat(d, tv[k].last && (i == tv[k].n - 1));
      end
      @(negedge clk);
      chk($sformatf("tv%0d_valid", k),
          DOUT_W'(bus.out_valid), 1);
      chk($sformatf("tv%0d_x", k), bus.x, tv[k].ex);
      chk($sformatf("tv%0d_cnt", k),
          DOUT_W'(bus.out_cnt), DOUT_W'(tv[k].ecnt));
      chk($sformatf("tv%0d_trunc", k),
          DOUT_W'(bus.out_trunc), DOUT_W'(tv[k].etr));
      @(posedge clk); #1;
    end

    // Backpressure holds output and stalls input.
    bus.out_ready = 1'b0;
    beat(1, 0);
    beat(2, 1);
    bus.in_valid = 1'b1;
    bus.din      = 3;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", DOUT_W'(bus.in_ready), 0);
      chk("bp_valid", DOUT_W'(bus.out_valid), 1);
      chk("bp_x", bus.x, 3);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", DOUT_W'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", DOUT_W'(bus.out_valid), 0);
    @(posedge clk); #1;
    beat(4, 1);
    @(negedge clk);
    chk("bp_next_x", bus.x, 7);
    chk("bp_next_cnt", DOUT_W'(bus.out_cnt), 2);
    @(posedge clk); #1;

    // Back-to-back single-beat groups.
    bus.in_valid = 1'b1;
    bus.din      = 4;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    bus.din = 6;
    @(negedge clk);
    chk("b2b_first_valid", DOUT_W'(bus.out_valid), 1);
    chk("b2b_first_x", bus.x, 4);
    chk("b2b_ready", DOUT_W'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", DOUT_W'(bus.out_valid), 1);
    chk("b2b_second_x", bus.x, 6);
    @(posedge clk); #1;

    // Reset mid-group discards the partial sum.
    beat(10, 0);
    beat(20, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", DOUT_W'(bus.in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", DOUT_W'(bus.out_valid), 0);
    chk("mid_rst_in_ready", DOUT_W'(bus.in_ready), 1);
    @(posedge clk); #1;
    beat(1, 1);
    @(negedge clk);
    chk("post_rst_x", bus.x, 1);
    chk("post_rst_cnt", DOUT_W'(bus.out_cnt), 1);
    chk("post_rst_trunc", DOUT_W'(bus.out_trunc), 0);
    @(posedge clk); #1;

    // Random stream against the group model.
    step(0, 0, 0, 1);
    mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rnd_din(),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7);
    end
    step(1, rnd_din(), 1, 1);
    for (int c = 0; c < 20; c++) step(0, 0, 0, 1);
    chk("rand_queue_empty", DOUT_W'(exp_q.size()), 0);
    chk("rand_group_empty", DOUT_W'(grp.size()), 0);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
